// File: rtl/sprite_palette_pkg.sv
// Shared types, the power-on sprite palette and a width helper for sprite_palette_bank.
package sprite_palette_pkg;

    localparam int PAL_CH_W = 4;

    typedef struct packed {
        logic [PAL_CH_W-1:0] r;
        logic [PAL_CH_W-1:0] g;
        logic [PAL_CH_W-1:0] b;
    } rgb_t;

    localparam rgb_t DEFAULT_PALETTE [16] = '{
        12'h050, 12'hAEA, 12'hFFF, 12'hF76, 12'h000, 12'h050, 12'hAEA, 12'hAEA,
        12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Palettes deeper than 16 entries fill the upper region with the background colour.
    function automatic rgb_t default_entry(input int idx);
        logic [3:0] low;
        low = idx[3:0];
        return (idx < 16) ? DEFAULT_PALETTE[low] : rgb_t'(12'hAEA);
    endfunction

endpackage

// File: rtl/sprite_palette_bank_cycle_ctrl.sv
// palette_cycle_ctrl: frame counter, cycle offset and index remap for palette animation.
module palette_cycle_ctrl
    import sprite_palette_pkg::*;
#(
    parameter int INDEX_W      = 4,
    parameter int CYCLE_LO     = 6,
    parameter int CYCLE_HI     = 11,
    parameter int CYCLE_PERIOD = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic               cycle_en,
    input  logic [INDEX_W-1:0] index,
    output logic [INDEX_W-1:0] remapped
);

    localparam int LEN   = CYCLE_HI - CYCLE_LO + 1;
    localparam int OFF_W = clog2(LEN + 1);
    localparam int CNT_W = (CYCLE_PERIOD > 1) ? clog2(CYCLE_PERIOD) : 1;

    localparam logic [INDEX_W-1:0] LO_I    = INDEX_W'(CYCLE_LO);
    localparam logic [INDEX_W-1:0] HI_I    = INDEX_W'(CYCLE_HI);
    localparam logic [OFF_W:0]     LEN_S   = (OFF_W + 1)'(LEN);
    localparam logic [OFF_W-1:0]   OFF_MAX = OFF_W'(LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CYCLE_PERIOD - 1);

    logic [CNT_W-1:0] frame_cnt;
    logic [OFF_W-1:0] offset;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_cnt <= '0;
            offset    <= '0;
        end else if (cycle_en && frame_tick) begin
            if (frame_cnt == CNT_MAX) begin
                frame_cnt <= '0;
                offset    <= (offset == OFF_MAX) ? '0 : offset + 1'b1;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    logic             in_range;
    logic [OFF_W-1:0] rel;
    logic [OFF_W:0]   sum;
    logic [OFF_W:0]   wrapped;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        in_range = 1'b0;
        rel      = '0;
        sum      = '0;
        wrapped  = '0;
        remapped = index;
        in_range = cycle_en && (index >= LO_I) && (index <= HI_I);
        rel      = OFF_W'(index - LO_I);
        sum      = {1'b0, rel} + {1'b0, offset};
        // rel and offset are both below LEN, so one conditional subtract is a full modulo.
        wrapped  = (sum >= LEN_S) ? sum - LEN_S : sum;
        if (in_range) remapped = LO_I + INDEX_W'(wrapped);
    end

endmodule

// File: rtl/sprite_palette_bank.sv
// Multi-bank writable sprite palette with 2-stage registered lookup and palette cycling.
// Optional macro PALETTE_FADE_EN adds fade_level, a per-channel right shift in stage 2.
module sprite_palette_bank
    import sprite_palette_pkg::*;
#(
    parameter int INDEX_W      = 4,
    parameter int CH_W         = 4,
    parameter int NUM_BANKS    = 4,
    parameter int TRANSP_IDX   = 0,
    parameter int CYCLE_LO     = 6,
    parameter int CYCLE_HI     = 11,
    parameter int CYCLE_PERIOD = 8,
    localparam int BANK_W      = clog2(NUM_BANKS)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_tick,
    input  logic                cycle_en,
    input  logic                pix_valid,
    input  logic [BANK_W-1:0]   bank_sel,
    input  logic [INDEX_W-1:0]  index,
    input  logic                wr_en,
    input  logic [BANK_W-1:0]   wr_bank,
    input  logic [INDEX_W-1:0]  wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
`ifdef PALETTE_FADE_EN
    input  logic [1:0]          fade_level,
`endif
    output logic                out_valid,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    output logic                transparent
);

    localparam int DEPTH = 1 << INDEX_W;

    function automatic logic [CH_W-1:0] widen(input logic [PAL_CH_W-1:0] v);
        logic [CH_W-1:0] w;
        w = '0;
        for (int j = 0; j < CH_W && j < PAL_CH_W; j++) w[CH_W-1-j] = v[PAL_CH_W-1-j];
        return w;
    endfunction

    function automatic logic [3*CH_W-1:0] default_word(input int idx);
        rgb_t c;
        c = default_entry(idx);
        return {widen(c.r), widen(c.g), widen(c.b)};
    endfunction

    logic [3*CH_W-1:0] mem [NUM_BANKS][DEPTH];

    // NOTE: the palette store is reset because reset must restore the default
    // palettes; this keeps it in flops rather than an inferred RAM.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int e = 0; e < DEPTH; e++) mem[b][e] <= default_word(e);
            end
        end else if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    logic [INDEX_W-1:0] remapped;

    palette_cycle_ctrl #(
        .INDEX_W      (INDEX_W),
        .CYCLE_LO     (CYCLE_LO),
        .CYCLE_HI     (CYCLE_HI),
        .CYCLE_PERIOD (CYCLE_PERIOD)
    ) u_cycle (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .cycle_en   (cycle_en),
        .index      (index),
        .remapped   (remapped)
    );

    logic               s1_valid;
    logic [BANK_W-1:0]  s1_bank;
    logic [INDEX_W-1:0] s1_idx;
    logic               s1_transp;
`ifdef PALETTE_FADE_EN
    logic [1:0]         s1_fade;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_valid  <= 1'b0;
            s1_bank   <= '0;
            s1_idx    <= '0;
            s1_transp <= 1'b0;
`ifdef PALETTE_FADE_EN
            s1_fade   <= '0;
`endif
        end else begin
            s1_valid  <= pix_valid;
            s1_bank   <= bank_sel;
            s1_idx    <= remapped;
            s1_transp <= (index == INDEX_W'(TRANSP_IDX));
`ifdef PALETTE_FADE_EN
            s1_fade   <= fade_level;
`endif
        end
    end

    // Read happens in the same edge as any write, so a colliding write is seen one lookup later.
    logic [3*CH_W-1:0] rd_word;
    assign rd_word = mem[s1_bank][s1_idx];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_valid   <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            transparent <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                transparent <= s1_transp;
`ifdef PALETTE_FADE_EN
                red   <= rd_word[3*CH_W-1 -: CH_W] >> s1_fade;
                green <= rd_word[2*CH_W-1 -: CH_W] >> s1_fade;
                blue  <= rd_word[CH_W-1   -: CH_W] >> s1_fade;
`else
                red   <= rd_word[3*CH_W-1 -: CH_W];
                green <= rd_word[2*CH_W-1 -: CH_W];
                blue  <= rd_word[CH_W-1   -: CH_W];
`endif
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed self-checking bench for sprite_palette_bank (default parameters).
module tb_sprite_palette_bank;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_tick;
    logic        cycle_en;
    logic        pix_valid;
    logic [1:0]  bank_sel;
    logic [3:0]  index;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
`ifdef PALETTE_FADE_EN
    logic [1:0]  fade_level;
`endif
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        transparent;

    int vectors    = 0;
    int miscompares = 0;

    sprite_palette_bank dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_tick  (frame_tick),
        .cycle_en    (cycle_en),
        .pix_valid   (pix_valid),
        .bank_sel    (bank_sel),
        .index       (index),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef PALETTE_FADE_EN
        .fade_level  (fade_level),
`endif
        .out_valid   (out_valid),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .transparent (transparent)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present one lookup and wait the two edges until its colour is on the outputs.
    task automatic lookup(input logic [1:0] b, input logic [3:0] i);
        bank_sel  = b;
        index     = i;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        tick();
    endtask

    task automatic write(input logic [1:0] b, input logic [3:0] a, input logic [11:0] d);
        wr_en   = 1'b1;
        wr_bank = b;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    task automatic expect_colour(input string name, input logic [11:0] want);
        vectors++;
        if (out_valid !== 1'b1 || {red, green, blue} !== want) begin
            miscompares++;
            $display("FAIL %s: got valid=%b rgb=%h, want valid=1 rgb=%h",
                     name, out_valid, {red, green, blue}, want);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        frame_tick = 0; cycle_en = 0; pix_valid = 0; bank_sel = 0; index = 0;
        wr_en = 0; wr_bank = 0; wr_addr = 0; wr_data = 0;
`ifdef PALETTE_FADE_EN
        fade_level = 0;
`endif
        tick();
        tick();
        vectors++;
        if ({out_valid, red, green, blue, transparent} !== 14'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {out_valid, red, green, blue, transparent});
        end
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        bank_sel = 2'd0; pix_valid = 1'b1; index = 4'd2;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_latency: out_valid=%b one edge after request, want 0", out_valid);
        end
        index = 4'd3;
        tick();
        expect_colour("b2b_idx2", 12'hFFF);
        vectors++;
        if (transparent !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_transp: got %b want 0", transparent);
        end
        index = 4'd4;
        tick();
        expect_colour("b2b_idx3", 12'hF76);
        pix_valid = 1'b0;
        tick();
        expect_colour("b2b_idx4", 12'h000);
        tick();
        vectors++;
        if (out_valid !== 1'b0 || {red, green, blue} !== 12'h000) begin
            miscompares++;
            $display("FAIL b2b_hold: got valid=%b rgb=%h, want valid=0 rgb=000",
                     out_valid, {red, green, blue});
        end
    endtask

    task automatic test_transparency();
        lookup(2'd0, 4'd0);
        expect_colour("transp_idx0", 12'h050);
        vectors++;
        if (transparent !== 1'b1) begin
            miscompares++;
            $display("FAIL transp_flag0: got %b want 1", transparent);
        end
        lookup(2'd0, 4'd1);
        expect_colour("transp_idx1", 12'hAEA);
        vectors++;
        if (transparent !== 1'b0) begin
            miscompares++;
            $display("FAIL transp_flag1: got %b want 0", transparent);
        end
    endtask

    task automatic test_writes();
        write(2'd2, 4'd7, 12'h123);
        lookup(2'd2, 4'd7);
        expect_colour("wr_bank2_idx7", 12'h123);
        lookup(2'd0, 4'd7);
        expect_colour("wr_bank0_untouched", 12'hAEA);
        // Lookup of bank1 idx3 reaches stage 2 on the same edge as its write.
        bank_sel = 2'd1; index = 4'd3; pix_valid = 1'b1;
        tick();
        wr_en = 1'b1; wr_bank = 2'd1; wr_addr = 4'd3; wr_data = 12'h456;
        tick();
        wr_en = 1'b0;
        expect_colour("rbw_old", 12'hF76);
        pix_valid = 1'b0;
        tick();
        expect_colour("rbw_new", 12'h456);
    endtask

    task automatic test_cycle();
        for (int i = 6; i <= 11; i++) write(2'd3, 4'(i), 12'(i * 12'h101));
        cycle_en = 1'b1;
        pulse_ticks(8);
        lookup(2'd3, 4'd11);
        expect_colour("cyc_off1_idx11", 12'h606);
        lookup(2'd3, 4'd6);
        expect_colour("cyc_off1_idx6", 12'h707);
        lookup(2'd3, 4'd5);
        expect_colour("cyc_off1_idx5_outside", 12'h050);
        pulse_ticks(40);
        lookup(2'd3, 4'd11);
        expect_colour("cyc_wrap_48", 12'hB0B);
        pulse_ticks(4);
        cycle_en = 1'b0;
        pulse_ticks(20);
        cycle_en = 1'b1;
        lookup(2'd3, 4'd11);
        expect_colour("cyc_frozen_offset", 12'hB0B);
        pulse_ticks(4);
        lookup(2'd3, 4'd11);
        expect_colour("cyc_counter_kept", 12'h606);
        cycle_en = 1'b0;
        lookup(2'd3, 4'd11);
        expect_colour("cyc_disabled_noremap", 12'hB0B);
    endtask

    task automatic test_midstream_reset();
        bank_sel = 2'd0; pix_valid = 1'b1; index = 4'd2;
        tick();
        index = 4'd3;
        tick();
        Reset_n = 1'b0;
        pix_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || {red, green, blue} !== 12'h000) begin
            miscompares++;
            $display("FAIL rst_flush: got valid=%b rgb=%h, want valid=0 rgb=000",
                     out_valid, {red, green, blue});
        end
        Reset_n = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_dropped: out_valid=%b after release, want 0", out_valid);
        end
        lookup(2'd2, 4'd7);
        expect_colour("rst_restore_b2i7", 12'hAEA);
        lookup(2'd1, 4'd3);
        expect_colour("rst_restore_b1i3", 12'hF76);
        lookup(2'd3, 4'd9);
        expect_colour("rst_restore_b3i9", 12'hAEA);
    endtask

`ifdef PALETTE_FADE_EN
    task automatic test_fade();
        fade_level = 2'd2;
        lookup(2'd0, 4'd2);
        expect_colour("fade2_idx2", 12'h333);
        lookup(2'd0, 4'd3);
        expect_colour("fade2_idx3", 12'h311);
        fade_level = 2'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_transparency();
        test_writes();
        test_cycle();
        test_midstream_reset();
`ifdef PALETTE_FADE_EN
        test_fade();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
Multi-bank, runtime-writable sprite colour palette with registered lookup, used between the sprite ROM index stream and the VGA colour mux.
- Generalises the fixed 16-entry sprite palettes: NUM_BANKS independent palettes, each reloadable from the CPU/asset loader.
- Adds frame-synchronous palette-cycle animation over an index range.
- Adds a transparency flag for the compositor.

Parameters:
INDEX_W, 4, index width; palette depth = 2**INDEX_W
CH_W, 4, bits per colour channel
NUM_BANKS, 4, number of palettes (power of 2, >=2)
TRANSP_IDX, 0, index reported as transparent
CYCLE_LO, 6, first index of cycle range
CYCLE_HI, 11, last index of cycle range (CYCLE_LO > TRANSP_IDX, CYCLE_HI < 2**INDEX_W)
CYCLE_PERIOD, 8, frame_tick count per cycle step (>=1)

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame (vsync)
cycle_en  in  1  enable palette-cycle animation
pix_valid  in  1  lookup request qualifier
bank_sel  in  log2(NUM_BANKS)  palette bank for this lookup
index  in  INDEX_W  sprite pixel index
wr_en  in  1  palette write strobe
wr_bank  in  log2(NUM_BANKS)  write bank
wr_addr  in  INDEX_W  write entry
wr_data  in  3*CH_W  {R,G,B}
out_valid  out  1  colour outputs valid
red, green, blue  out  CH_W each  looked-up colour
transparent  out  1  raw index == TRANSP_IDX

Behaviour:
- One clock, Clk; reset is synchronous, active-low (Reset_n).
- Reset:
  - Every bank is loaded with DEFAULT_PALETTE: idx0=050, idx1=AEA, idx2=FFF, idx3=F76, idx4=000, idx5=050, all others AEA (12-bit values for CH_W=4).
  - out_valid=0; red, green, blue=0; transparent=0.
  - Frame counter=0; cycle offset=0.
  - Reset mid-stream drops all in-flight lookups.
- Lookup pipeline, fixed latency 2 (inputs sampled at edge N, outputs at edge N+2):
  - Stage 1 registers: valid, bank, remapped index, transparency (computed from the raw index).
  - Stage 2 registers: palette[bank][remapped] onto red, green and blue; valid onto out_valid; transparency onto transparent.
  - Accepts one request per cycle; no backpressure.
  - When out_valid=0, colour outputs hold their last value.
- Remap: if cycle_en=1 and CYCLE_LO <= index <= CYCLE_HI, then remapped = CYCLE_LO + ((index - CYCLE_LO + offset) mod LEN), where LEN = CYCLE_HI - CYCLE_LO + 1. Otherwise remapped = index.
- Cycle animation:
  - Frame counter advances on frame_tick when cycle_en=1.
  - At CYCLE_PERIOD-1 plus a tick: counter wraps to 0 and offset = (offset+1) mod LEN.
  - cycle_en=0 freezes both the counter and the offset; they are not cleared.
- Writes:
  - A wr_en write updates the entry at the next edge.
  - A stage-2 read of the same entry in the same cycle returns the old data (read-before-write).
  - A write and a lookup in different banks or entries do not interact.
- Arithmetic: offset and remap use ceil(log2(LEN+1))-bit unsigned math; the mod is implemented as a compare-and-subtract, with no divider.

Optional Feature:
PALETTE_FADE_EN
- Defined: adds input fade_level [1:0]. Each output channel = palette channel >> fade_level, applied in stage 2. fade_level is sampled with the stage-1 request, so latency is unchanged.
- Undefined: no port; channels pass through unshifted.

Decomposition:
- Package sprite_palette_pkg holds:
  - rgb_t packed struct {r,g,b} of CH_W each
  - DEFAULT_PALETTE constant array
  - a clog2 helper
- One sub-module, palette_cycle_ctrl: frame counter, offset register and remap function output. It has its own unit test.

Test Plan:
- Reset then request bank0 idx2/3/4 back-to-back -> out_valid high 2 cycles later for 3 cycles, colours FFF, F76, 000; transparent=0.
- Request idx0 -> transparent=1, colour 050; request idx1 -> transparent=0, colour AEA.
- Write bank2 idx7=123, then lookup bank2 idx7 -> 123; bank0 idx7 still AEA. Same-cycle write+read of bank1 idx3=456 -> old F76, next lookup 456.
- cycle_en=1, 8 frame_ticks:
  - offset=1; idx11 maps to idx6.
  - After 48 ticks offset wraps to 0.
  - With cycle_en=0, 20 more ticks -> offset unchanged.
- Assert Reset_n=0 with 2 lookups in flight -> out_valid=0 next edge; written entries restored to DEFAULT_PALETTE.
- PALETTE_FADE_EN, fade_level=2, idx2 -> 333.
